// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with a single-entry output register,
// a sticky overrun flag and a one-cycle frame-error pulse for abandoned words.
module deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_bit,
  input  logic             in_enable,
  input  logic             in_start,
  input  logic             in_clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_busy,
  output logic             out_overrun,
  output logic             out_frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             word_done;
  logic [WIDTH-1:0] word;

  // The word is assembled LSB-side, so the first bit reaches the MSB after WIDTH shifts.
  assign word = {sr_q[WIDTH-2:0], in_bit};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_enable && in_start) begin
          sr_d    = {{(WIDTH-1){1'b0}}, in_bit};
          cnt_d   = CW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (in_enable) begin
          if (cnt_q == LastCnt) begin
            // Last bit wins over a coincident in_start.
            word_done = 1'b1;
            sr_d      = '0;
            cnt_d     = '0;
            state_d   = StIdle;
          end else if (in_start) begin
            frame_err_d = 1'b1;
            sr_d        = {{(WIDTH-1){1'b0}}, in_bit};
            cnt_d       = CW'(1);
          end else begin
            sr_d  = word;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (in_clear) begin
      overrun_d = 1'b0;
    end

    if (word_done) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_busy      = (state_q == StShift);
  assign out_overrun   = overrun_q;
  assign out_frame_err = frame_err_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus randomized traffic
// compared against an arithmetic word-assembly model.
module tb_deserializer;

  localparam int unsigned WIDTH = 8;

  logic             in_clock;
  logic             in_reset_n;
  logic             in_bit;
  logic             in_enable;
  logic             in_start;
  logic             in_clear;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_busy;
  logic             out_overrun;
  logic             out_frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit               m_act;
  int               m_cnt;
  longint unsigned  m_acc;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_ovr;
  bit               m_ferr;

  deserializer #(.WIDTH(WIDTH)) dut (
    .in_clock     (in_clock),
    .in_reset_n   (in_reset_n),
    .in_bit       (in_bit),
    .in_enable    (in_enable),
    .in_start     (in_start),
    .in_clear     (in_clear),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_busy     (out_busy),
    .out_overrun  (out_overrun),
    .out_frame_err(out_frame_err)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  task automatic model_reset();
    m_act = 0; m_cnt = 0; m_acc = 0;
    m_valid = 0; m_data = '0; m_ovr = 0; m_ferr = 0;
  endtask

  // Word collected as an integer: acc = acc*2 + bit, completed after WIDTH bits.
  task automatic model_step(input bit en, input bit st, input bit b, input bit rdy,
                            input bit clr);
    bit               done = 0;
    bit               ferr = 0;
    logic [WIDTH-1:0] w = '0;
    bit               was_valid = m_valid;
    if (en) begin
      if (!m_act) begin
        if (st) begin m_act = 1; m_acc = b; m_cnt = 1; end
      end else if (m_cnt + 1 == WIDTH) begin
        done = 1; w = WIDTH'(m_acc * 2 + b); m_act = 0; m_cnt = 0; m_acc = 0;
      end else if (st) begin
        ferr = 1; m_acc = b; m_cnt = 1;
      end else begin
        m_acc = m_acc * 2 + b; m_cnt = m_cnt + 1;
      end
    end
    if (clr) m_ovr = 0;
    if (done) begin
      if (!was_valid || rdy) begin m_data = w; m_valid = 1; end
      else m_ovr = 1;
    end else if (was_valid && rdy) begin
      m_valid = 0;
    end
    m_ferr = ferr;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit en, input bit st, input bit b, input bit rdy, input bit clr);
    in_enable = en; in_start = st; in_bit = b; out_ready = rdy; in_clear = clr;
    model_step(en, st, b, rdy, clr);
    @(posedge in_clock);
    @(negedge in_clock);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_pre, input bit rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      drive(1, i == WIDTH - 1, w[i], (i == 0) ? rdy_last : rdy_pre, 0);
    end
  endtask

  task automatic apply_reset();
    @(negedge in_clock);
    in_reset_n = 1'b0;
    in_enable = 0; in_start = 0; in_bit = 0; in_clear = 0; out_ready = 0;
    model_reset();
    @(negedge in_clock);
    in_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_reset_n = 1'b0;
    in_enable = 0; in_start = 0; in_bit = 0; in_clear = 0; out_ready = 0;
    model_reset();
    #1;
    n_checks++;
    if ({out_data, out_valid, out_busy, out_overrun, out_frame_err} !== '0)
      $display("FAIL reset_outputs: got data=%h v=%b b=%b o=%b f=%b, want all 0",
               out_data, out_valid, out_busy, out_overrun, out_frame_err);
    else n_pass++;
    @(negedge in_clock);
    in_reset_n = 1'b1;
    // Enables without start in IDLE are ignored.
    drive(1, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0);
    n_checks++;
    if (out_busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL idle_ignore: got busy=%b valid=%b, want 0 0", out_busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int valid_cycles = 0;
    apply_reset();
    drive(1, 1, 1, 1, 0);
    n_checks++;
    if (out_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", out_busy);
    else n_pass++;
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid);
    else n_pass++;
    drive(1, 0, 1, 1, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_busy !== 1'b0)
      $display("FAIL basic_word: got v=%b data=%h busy=%b want 1 a5 0",
               out_valid, out_data, out_busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) valid_cycles++;
      drive(0, 0, 0, 1, 0);
    end
    n_checks++;
    if (valid_cycles != 1 || out_data !== 8'hA5)
      $display("FAIL basic_valid_len: got %0d cycles data=%h want 1 a5", valid_cycles, out_data);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [7:0] w = 8'hA5;
    int busy_bad = 0;
    apply_reset();
    for (int i = 7; i >= 0; i--) begin
      drive(1, i == 7, w[i], 1, 0);
      if (i != 0) begin
        for (int g = 0; g < 2; g++) begin
          if (out_busy !== 1'b1) busy_bad++;
          drive(0, 0, $urandom_range(0, 1), 1, 0);
        end
      end
    end
    n_checks++;
    if (busy_bad != 0) $display("FAIL gap_busy: got %0d low-busy cycles want 0", busy_bad);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL gap_word: got v=%b data=%h want 1 a5", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_overrun();
    apply_reset();
    send_word(8'h3C, 0, 0);
    send_word(8'hFF, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_overrun !== 1'b1)
      $display("FAIL overrun_set: got v=%b data=%h ovr=%b want 1 3c 1",
               out_valid, out_data, out_overrun);
    else n_pass++;
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (out_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", out_overrun);
    else n_pass++;
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (out_overrun !== 1'b0 || out_data !== 8'h3C)
      $display("FAIL overrun_clear: got ovr=%b data=%h want 0 3c", out_overrun, out_data);
    else n_pass++;
    // Clear and new overrun on the same edge: set wins.
    for (int i = 7; i >= 0; i--) drive(1, i == 7, 1'b1, 0, i == 0);
    n_checks++;
    if (out_overrun !== 1'b1) $display("FAIL overrun_set_wins: got %b want 1", out_overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_word(8'h3C, 0, 0);
    send_word(8'h81, 0, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h81 || out_overrun !== 1'b0)
      $display("FAIL b2b_accept: got v=%b data=%h ovr=%b want 1 81 0",
               out_valid, out_data, out_overrun);
    else n_pass++;
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h81)
      $display("FAIL b2b_drain: got v=%b data=%h want 0 81", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    apply_reset();
    drive(1, 1, 1, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0);
    n_checks++;
    if (out_frame_err !== 1'b0) $display("FAIL ferr_quiet: got %b want 0", out_frame_err);
    else n_pass++;
    drive(1, 1, 0, 1, 0);
    n_checks++;
    if (out_frame_err !== 1'b1 || out_busy !== 1'b1)
      $display("FAIL ferr_pulse: got ferr=%b busy=%b want 1 1", out_frame_err, out_busy);
    else n_pass++;
    drive(1, 0, 1, 1, 0);
    n_checks++;
    if (out_frame_err !== 1'b0) $display("FAIL ferr_one_cycle: got %b want 0", out_frame_err);
    else n_pass++;
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0); drive(1, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0); drive(1, 0, 1, 1, 0);
    // Start on the last bit is ignored: no error, word completes.
    drive(1, 1, 0, 1, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_frame_err !== 1'b0 || out_busy !== 1'b0)
      $display("FAIL ferr_word: got v=%b data=%h ferr=%b busy=%b want 1 5a 0 0",
               out_valid, out_data, out_frame_err, out_busy);
    else n_pass++;
  endtask

  task automatic test_midword_reset();
    int valid_seen = 0;
    apply_reset();
    send_word(8'hC3, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, i == 0, 1'b1, 0, 0);
    in_reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_data, out_valid, out_busy, out_overrun, out_frame_err} !== '0)
      $display("FAIL async_reset: got data=%h v=%b b=%b o=%b f=%b want all 0",
               out_data, out_valid, out_busy, out_overrun, out_frame_err);
    else n_pass++;
    @(negedge in_clock);
    in_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1'b1, 0, 0);
      if (out_valid || out_busy) valid_seen++;
    end
    n_checks++;
    if (valid_seen != 0) $display("FAIL reset_needs_start: got %0d active cycles want 0", valid_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 12, $urandom_range(0, 1),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
      n_checks++;
      if (out_valid !== m_valid || (m_valid && out_data !== m_data) || out_busy !== m_act ||
          out_overrun !== m_ovr || out_frame_err !== m_ferr)
        $display("FAIL rand_cycle%0d: got v=%b d=%h b=%b o=%b f=%b want v=%b d=%h b=%b o=%b f=%b",
                 i, out_valid, out_data, out_busy, out_overrun, out_frame_err,
                 m_valid, m_data, m_act, m_ovr, m_ferr);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_midword_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
